i2s_transmitter: RTL and testbench
==================================

Name: i2s_transmitter

Overview:
- Serialises stereo PCM samples onto an I2S link (BCLK, LRCLK, DIN) for an external DAC or codec. It is the transmit-side counterpart of the microphone receiver path.
- Sits beside the audio front end. The processing side pushes left/right sample pairs through a valid/ready handshake into a one-deep holding buffer.
- The block is the link master: it generates BCLK and LRCLK from clk.

Parameters:
- SAMPLE_W, 16, bits per sample (two's complement, MSB first); must be <= SLOT_W.
- SLOT_W, 32, BCLK periods per channel slot; frame = 2*SLOT_W BCLK periods.
- BCLK_DIV, 8, clk cycles per BCLK half-period (>=1). BCLK = clk/(2*BCLK_DIV); 50 MHz gives 3.125 MHz BCLK and a 48.83 kHz frame rate.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  run enable; sampled at frame boundaries.
- sample_l  in  SAMPLE_W  left sample.
- sample_r  in  SAMPLE_W  right sample.
- sample_valid  in  1  sample pair offered.
- sample_ready  out  1  holding buffer empty; a transfer occurs when valid && ready.
- BCLK  out  1  bit clock.
- LRCLK  out  1  word select (0 = left, 1 = right).
- DIN  out  1  serial data to the DAC.
- underrun  out  1  one-clk pulse when a frame starts with no sample pair available.

Behaviour:
- Reset state (all outputs registered): BCLK=0, LRCLK=0, DIN=0, sample_ready=1, underrun=0. State is IDLE, holding buffer empty, bit counter b=2*SLOT_W-1, divider=0.
- Holding buffer:
  - An accept (valid && ready) latches sample_l and sample_r, sets hold_full, and drives sample_ready=0 from the next cycle.
  - sample_ready=!hold_full. Accept and transfer are never simultaneous, because transfer requires hold_full.
- FSM IDLE:
  - BCLK, LRCLK and DIN are held at their reset values; the divider is stopped.
  - Go to RUN when en=1 && hold_full. The divider restarts at 0 and b stays at 2*SLOT_W-1.
- FSM RUN, divider:
  - The divider counts 0..BCLK_DIV-1. At the terminal count BCLK toggles.
  - A 1->0 toggle is a falling-edge event. All DIN/LRCLK/b updates occur in the same clk cycle as the falling-edge event.
  - First falling edge: 2*BCLK_DIV clk cycles after entering RUN.
- Bit counter: at each falling edge b advances modulo 2*SLOT_W.
- Frame boundary (b wraps 2*SLOT_W-1 -> 0):
  - If hold_full: copy the holding buffer to the frame registers and clear hold_full.
  - Else: load zeros and pulse underrun for one clk.
  - If en=0 at this event: go to IDLE instead, with no load, outputs returned to reset values, and the holding buffer kept.
- DIN at slot b (driven on the falling edge that enters b):
  - b in 0..SAMPLE_W-1: left[SAMPLE_W-1-b].
  - b in SAMPLE_W..SLOT_W-1: 0.
  - b in SLOT_W..SLOT_W+SAMPLE_W-1: right[SAMPLE_W-1-(b-SLOT_W)].
  - Else: 0.
  - The left MSB appears on the same edge as the load.
- LRCLK: 1 for b in SLOT_W-1..2*SLOT_W-2, else 0. It transitions one BCLK before each channel MSB (standard I2S one-bit delay).
- A new pair accepted mid-frame waits in the holding buffer; the frame being shifted is never disturbed.
- Reset asserted mid-frame forces the reset state immediately; the partial frame is abandoned.

Decomposition:
- Package i2s_pkg: SAMPLE_W and SLOT_W defaults, FSM state typedef {IDLE, RUN}, frame-bit-index helper constants. The package is shared with the receiver.
- One sub-module: i2s_clk_gen (divider, BCLK toggle, falling-edge strobe, b counter, LRCLK decode).
- The top level holds the handshake buffer, frame registers, DIN mux and FSM.

Test Plan:
- Reset, then en=1 and push L=16'hA5F0, R=16'h0F0F:
  - sample_ready drops for 1 clk after accept, then recovers at the b=0 load.
  - Sampling DIN on BCLK rising edges yields 1010_0101_1111_0000 + 16 zeros, then 0000_1111_0000_1111 + 16 zeros.
  - LRCLK rises one BCLK before the right MSB.
- Timing check: BCLK period is 16 clk and LRCLK period is 1024 clk (defaults). There is no BCLK activity before the first accept.
- Push a single pair, then nothing:
  - The next frame carries all-zero DIN.
  - underrun pulses exactly once per starved frame, at b=0.
- Back-to-back pushes with valid held high:
  - Exactly one accept per frame.
  - No lost or duplicated pairs across 8 frames (scoreboard).
- Drop en mid-frame:
  - The current frame completes.
  - At the wrap point BCLK=LRCLK=DIN=0 and the block is in IDLE.
  - A pending pair is kept and transmitted first after en returns.
- Assert rst for 1 clk mid-right-slot: all outputs are at reset values in the same cycle, the holding buffer is empty, and sample_ready=1.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared definitions for the I2S transmit and receive paths.
//   - default sample/slot geometry and bit-clock divider
//   - FSM state type
//   - frame bit-index helpers (bit counter width, wrap index, LRCLK window)
package i2s_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int SLOT_W_DEF   = 32;
  localparam int BCLK_DIV_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_t;

  // Width of the frame bit counter b (0 .. 2*SLOT_W-1).
  function automatic int bidx_w(input int slot_w);
    return $clog2(2 * slot_w);
  endfunction

  // Last bit index of a frame; b wraps from here to 0.
  function automatic int frame_last(input int slot_w);
    return 2 * slot_w - 1;
  endfunction

  // LRCLK is high for b in [lr_lo, lr_hi]: one bit ahead of each channel
  // MSB, giving the standard one-BCLK I2S word-select lead.
  function automatic int lr_lo(input int slot_w);
    return slot_w - 1;
  endfunction

  function automatic int lr_hi(input int slot_w);
    return 2 * slot_w - 2;
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: bit-clock generator and frame bit counter for the I2S master.
//   clk, rst : system clock, async active-high reset
//   run      : divider runs while high; when low everything parks at reset
//   halt     : at the next frame wrap, park b at the last index instead of
//              starting a new frame
//   bclk     : registered bit clock (clk / (2*BCLK_DIV))
//   lrclk    : registered word select, decoded from the bit index
//   fall     : one-clk strobe in the cycle whose edge drives BCLK 1->0
//   wrap     : fall strobe that also moves b from the last index to 0
//   b_next   : bit index that b takes at this falling edge
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int SLOT_W   = SLOT_W_DEF,
  parameter int BCLK_DIV = BCLK_DIV_DEF,
  localparam int BW      = bidx_w(SLOT_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          halt,
  output logic          bclk,
  output logic          lrclk,
  output logic          fall,
  output logic          wrap,
  output logic [BW-1:0] b_next
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(frame_last(SLOT_W));
  localparam logic [BW-1:0] LR_LO    = BW'(lr_lo(SLOT_W));
  localparam logic [BW-1:0] LR_HI    = BW'(lr_hi(SLOT_W));

  logic [DW-1:0] div;
  logic [BW-1:0] b;
  logic          tc;

  assign tc     = run && (div == DIV_LAST);
  assign fall   = tc && bclk;
  assign wrap   = fall && (b == B_LAST);
  assign b_next = (b == B_LAST) ? '0 : b + BW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div   <= '0;
      bclk  <= 1'b0;
      lrclk <= 1'b0;
      b     <= B_LAST;
    end else if (!run) begin
      // Parked at b = last so the first falling edge after restart is a
      // frame boundary and carries the left MSB.
      div   <= '0;
      bclk  <= 1'b0;
      lrclk <= 1'b0;
      b     <= B_LAST;
    end else if (tc) begin
      div  <= '0;
      bclk <= ~bclk;
      if (fall) begin
        if (wrap && halt) begin
          b     <= B_LAST;
          lrclk <= 1'b0;
        end else begin
          b     <= b_next;
          lrclk <= (b_next >= LR_LO) && (b_next <= LR_HI);
        end
      end
    end else begin
      div <= div + DW'(1);
    end
  end

endmodule

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: I2S link master serialising stereo PCM to a DAC/codec.
//   clk, rst              : system clock, async active-high reset
//   en                    : run enable, acted on at frame boundaries
//   sample_l/sample_r     : sample pair (two's complement, MSB first)
//   sample_valid/ready    : handshake into a one-deep holding buffer
//   BCLK, LRCLK, DIN      : I2S link outputs (all registered)
//   underrun              : one-clk pulse when a frame starts with no pair
// The holding buffer decouples the producer from the frame registers; the
// frame being shifted is only replaced at a frame boundary.
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int SLOT_W   = SLOT_W_DEF,
  parameter int BCLK_DIV = BCLK_DIV_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                BCLK,
  output logic                LRCLK,
  output logic                DIN,
  output logic                underrun
);

  localparam int BW  = bidx_w(SLOT_W);
  localparam int SIW = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
  localparam logic [BW-1:0] SLOT_B   = BW'(SLOT_W);
  localparam logic [BW-1:0] SAMP_B   = BW'(SAMPLE_W);
  localparam logic [BW-1:0] SAMP_MSB = BW'(SAMPLE_W - 1);

  // Pair layout: [0] = left, [1] = right.
  typedef logic [1:0][SAMPLE_W-1:0] pair_t;

  i2s_state_t    state;
  logic          hold_full;
  pair_t         hold_q;
  pair_t         frame_q;
  logic          accept;
  logic          run;
  logic          fall;
  logic          wrap;
  logic [BW-1:0] b_next;

  assign accept = sample_valid && sample_ready;
  assign run    = (state == RUN);

  // Serial bit for frame position bi: channel MSB first, then zero padding
  // to the end of the slot.
  function automatic logic din_bit(input logic [BW-1:0] bi, input pair_t pr);
    logic          rs;
    logic [BW-1:0] off;
    rs  = (bi >= SLOT_B);
    off = rs ? bi - SLOT_B : bi;
    if (off < SAMP_B) din_bit = pr[rs][SIW'(SAMP_MSB - off)];
    else              din_bit = 1'b0;
  endfunction

  i2s_clk_gen #(
    .SLOT_W   (SLOT_W),
    .BCLK_DIV (BCLK_DIV)
  ) u_clk_gen (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .halt   (!en),
    .bclk   (BCLK),
    .lrclk  (LRCLK),
    .fall   (fall),
    .wrap   (wrap),
    .b_next (b_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hold_full    <= 1'b0;
      sample_ready <= 1'b1;
      hold_q       <= '0;
      frame_q      <= '0;
      DIN          <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      underrun <= 1'b0;

      // Accept needs an empty buffer and a load needs a full one, so the
      // two never collide on hold_full.
      if (accept) begin
        hold_q       <= {sample_r, sample_l};
        hold_full    <= 1'b1;
        sample_ready <= 1'b0;
      end

      case (state)
        IDLE: begin
          DIN <= 1'b0;
          if (en && hold_full) state <= RUN;
        end
        RUN: begin
          if (fall) begin
            if (wrap) begin
              if (!en) begin
                // Stop cleanly at the boundary; a pending pair stays put.
                state <= IDLE;
                DIN   <= 1'b0;
              end else if (hold_full) begin
                frame_q      <= hold_q;
                hold_full    <= 1'b0;
                sample_ready <= 1'b1;
                DIN          <= din_bit(b_next, hold_q);
              end else begin
                frame_q  <= '0;
                underrun <= 1'b1;
                DIN      <= 1'b0;
              end
            end else begin
              DIN <= din_bit(b_next, frame_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Scoreboard bench for i2s_transmitter. The driver records every accepted
// pair with the clk edge it was taken on; the monitor rebuilds each 64-bit
// frame from DIN/LRCLK sampled at BCLK rising edges and compares it to the
// pair the specification says that frame must carry.
module tb_i2s_transmitter;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int SW      = 16;
  localparam int SLOT    = 32;
  localparam int DIV     = 8;
  localparam int BITS    = 2 * SLOT;
  localparam int BCLK_P  = 2 * DIV;
  localparam int FRAME_P = BITS * BCLK_P;
  localparam logic [BITS-1:0] LR_EXP = {{(SLOT-1){1'b0}}, {SLOT{1'b1}}, 1'b0};

  logic          clk = 1'b0;
  logic          rst, en, sample_valid;
  logic [SW-1:0] sample_l, sample_r;
  logic          sample_ready, BCLK, LRCLK, DIN, underrun;

  i2s_transmitter #(.SAMPLE_W(SW), .SLOT_W(SLOT), .BCLK_DIV(DIV)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .BCLK         (BCLK),
    .LRCLK        (LRCLK),
    .DIN          (DIN),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    int            t;   // clk edge on which the accept happened
  } pair_t;

  pair_t sbq[$];
  int n_chk = 0, n_pass = 0, ur_seen = 0, ur_exp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic            prev_bclk, prev_lr, in_run, lr_have, per_ok, exp_ur;
    int              mon_bit, last_rise, last_lr, last_ur, t_l;
    logic [BITS-1:0] din_v, lr_v;
    logic [SW-1:0]   exp_l, exp_r;
    pair_t           e;
    prev_bclk = 0; prev_lr = 0; in_run = 0; lr_have = 0; per_ok = 1; exp_ur = 0;
    mon_bit = 0; last_rise = 0; last_lr = 0; last_ur = -1000;
    din_v = '0; lr_v = '0; exp_l = '0; exp_r = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_bclk = 0; prev_lr = 0; in_run = 0; lr_have = 0; mon_bit = 0;
      end else begin
        if (underrun) begin ur_seen++; last_ur = cyc; end
        if (LRCLK && !prev_lr) begin
          if (lr_have) chk("lrclk_period", 64'(cyc - last_lr), 64'(FRAME_P));
          lr_have = 1; last_lr = cyc;
        end
        if (BCLK && !prev_bclk) begin
          if (!in_run || (cyc - last_rise) > 4 * BCLK_P) begin
            // First rising edge of a run belongs to the parked last bit.
            chk("run_lead_bit", {62'd0, LRCLK, DIN}, 64'd0);
            in_run = 1; mon_bit = 0; lr_have = 0;
          end else begin
            if (mon_bit == 0) begin
              per_ok = 1;
              // The load happened on the falling edge half a BCLK ago.
              t_l = cyc - DIV;
              if (sbq.size() > 0 && sbq[0].t < t_l) begin
                e = sbq.pop_front();
                exp_l = e.l; exp_r = e.r; exp_ur = 0;
              end else begin
                exp_l = '0; exp_r = '0; exp_ur = 1; ur_exp++;
              end
              chk("underrun_at_b0", {63'd0, last_ur == t_l}, {63'd0, exp_ur});
            end
            if (cyc - last_rise != BCLK_P) per_ok = 0;
            din_v[BITS-1-mon_bit] = DIN;
            lr_v[BITS-1-mon_bit]  = LRCLK;
            if (mon_bit == BITS - 1) begin
              chk("frame_din", din_v, {exp_l, {(SLOT-SW){1'b0}}, exp_r, {(SLOT-SW){1'b0}}});
              chk("frame_lrclk", lr_v, LR_EXP);
              chk("bclk_period", {63'd0, per_ok}, 64'd1);
              mon_bit = 0;
            end else begin
              mon_bit++;
            end
          end
          last_rise = cyc;
        end
        prev_bclk = BCLK; prev_lr = LRCLK;
      end
    end
  end

  // ---------------- driver helpers (called at a negedge) ----------------
  task automatic push(input logic [SW-1:0] l, input logic [SW-1:0] r, input bit keep);
    int n = 0;
    sample_l = l; sample_r = r; sample_valid = 1'b1;
    while (!sample_ready && n < 3 * FRAME_P) begin @(negedge clk); n++; end
    chk("accept_in_time", {63'd0, sample_ready}, 64'd1);
    if (!sample_ready) begin sample_valid = 1'b0; return; end
    sbq.push_back('{l, r, cyc + 1});
    @(negedge clk);
    chk("ready_drop", {63'd0, sample_ready}, 64'd0);
    if (!keep) sample_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!sample_ready && n < 2 * FRAME_P) begin @(negedge clk); n++; end
    chk("ready_recover", {63'd0, sample_ready}, 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0, stable = 0;
    while (stable < 4 * BCLK_P && n < 2 * FRAME_P) begin
      @(negedge clk); n++;
      if (BCLK) stable = 0; else stable++;
    end
    chk("link_stopped", {63'd0, stable >= 4 * BCLK_P}, 64'd1);
  endtask

  task automatic quiet(input int cycles, input string name);
    logic act = 1'b0;
    repeat (cycles) begin @(negedge clk); act = act | BCLK | LRCLK | DIN; end
    chk(name, {63'd0, act}, 64'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: run did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1; en = 1'b0; sample_valid = 1'b0; sample_l = '0; sample_r = '0;
    repeat (3) @(negedge clk);
    chk("reset_link", {61'd0, BCLK, LRCLK, DIN}, 64'd0);
    chk("reset_hs", {62'd0, sample_ready, underrun}, 64'd2);
    rst = 1'b0;
    en  = 1'b1;
    quiet(100, "no_bclk_before_accept");

    // Directed pair from IDLE; ready stays low until the first load.
    push(16'hA5F0, 16'h0F0F, 1'b0);
    n = 0;
    while (!sample_ready && n < 4 * BCLK_P) begin @(negedge clk); n++; end
    chk("ready_low_cycles", 64'(n), 64'(2 * DIV + 1));
    repeat (3 * FRAME_P) @(negedge clk);   // pair, then starved frames

    // Back-to-back with valid held high.
    for (int i = 0; i < 8; i++) push(SW'($urandom), SW'($urandom), 1'b1);
    sample_valid = 1'b0;
    repeat (2 * FRAME_P) @(negedge clk);

    // Drop en mid-frame with a pair pending.
    push(SW'($urandom), SW'($urandom), 1'b0);
    wait_ready();
    push(SW'($urandom), SW'($urandom), 1'b0);
    repeat (300) @(negedge clk);
    en = 1'b0;
    wait_idle();
    chk("stop_outputs", {61'd0, BCLK, LRCLK, DIN}, 64'd0);
    chk("pending_kept", {63'd0, sample_ready}, 64'd0);
    quiet(200, "idle_while_disabled");
    en = 1'b1;
    repeat (3 * FRAME_P) @(negedge clk);

    // Reset pulse in the middle of the right slot.
    push(SW'($urandom), SW'($urandom), 1'b0);
    wait_ready();
    push(SW'($urandom), SW'($urandom), 1'b0);
    repeat ((SLOT + 8) * BCLK_P) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("midframe_rst_link", {61'd0, BCLK, LRCLK, DIN}, 64'd0);
    chk("midframe_rst_hs", {62'd0, sample_ready, underrun}, 64'd2);
    sbq.delete();
    @(posedge clk); #2 rst = 1'b0;
    quiet(200, "idle_after_rst");
    chk("ready_after_rst", {63'd0, sample_ready}, 64'd1);

    // Recovery run, then stop.
    push(SW'($urandom), SW'($urandom), 1'b0);
    repeat (FRAME_P + FRAME_P / 2) @(negedge clk);
    en = 1'b0;
    wait_idle();
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    chk("underrun_count", 64'(ur_seen), 64'(ur_exp));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
